// File: rtl/dummy_ip_pkg.sv
// Shared AXI4-Lite response codes, write/read FSM state types and the byte-strobe merge helper
// used by the dummy_ip register-bank slave.
package dummy_ip_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        W_IDLE,
        W_RESP
    } wr_state_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rd_state_t;

    function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  strb);
        logic [31:0] merged;
        merged = old_word;
        for (int unsigned b = 0; b < 4; b++) begin
            if (strb[b]) merged[8*b +: 8] = new_word[8*b +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/dummy_ip_s00_axi_slave_if.sv
// AXI4-Lite channel bundle for the dummy_ip slave; master drives requests, slave drives
// ready/response signals.
interface dummy_ip_s00_axi_slave_if #(
    parameter int unsigned ADDR_WIDTH = 6
);
    logic [ADDR_WIDTH-1:0] AWADDR;
    logic [2:0]            AWPROT;
    logic                  AWVALID;
    logic                  AWREADY;
    logic [31:0]           WDATA;
    logic [3:0]            WSTRB;
    logic                  WVALID;
    logic                  WREADY;
    logic [1:0]            BRESP;
    logic                  BVALID;
    logic                  BREADY;
    logic [ADDR_WIDTH-1:0] ARADDR;
    logic [2:0]            ARPROT;
    logic                  ARVALID;
    logic                  ARREADY;
    logic [31:0]           RDATA;
    logic [1:0]            RRESP;
    logic                  RVALID;
    logic                  RREADY;

    modport master (
        output AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
               ARADDR, ARPROT, ARVALID, RREADY,
        input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );

    modport slave (
        input  AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
               ARADDR, ARPROT, ARVALID, RREADY,
        output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );

endinterface

// File: rtl/dummy_ip_regfile.sv
// NUM_REGS x 32-bit register storage: one byte-strobed write port, one combinational read
// port (reads 0 for out-of-range indices) and a flattened view of all registers.
module dummy_ip_regfile
    import dummy_ip_pkg::*;
#(
    parameter int unsigned NUM_REGS  = 4,
    parameter int unsigned IDX_W     = 4,
    parameter logic [31:0] RESET_VAL = 32'h0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [IDX_W-1:0]         wr_idx,
    input  logic [31:0]              wr_data,
    input  logic [3:0]               wr_strb,
    input  logic [IDX_W-1:0]         rd_idx,
    output logic [31:0]              rd_data,
    output logic [NUM_REGS*32-1:0]   regs_o
);

    logic [31:0] regs [NUM_REGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < NUM_REGS; k++) regs[k] <= RESET_VAL;
        end else if (wr_en) begin
            for (int unsigned k = 0; k < NUM_REGS; k++) begin
                if (wr_idx == IDX_W'(k)) regs[k] <= byte_merge(regs[k], wr_data, wr_strb);
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int unsigned k = 0; k < NUM_REGS; k++) begin
            if (rd_idx == IDX_W'(k)) rd_data = regs[k];
        end
    end

    always_comb begin
        regs_o = '0;
        for (int unsigned k = 0; k < NUM_REGS; k++) regs_o[32*k +: 32] = regs[k];
    end

endmodule

// File: rtl/dummy_ip_s00_axi_slave.sv
// AXI4-Lite slave register bank with independent single-outstanding write and read FSMs.
// Define DUMMY_IP_SLVERR_EN to answer out-of-range accesses with SLVERR instead of OKAY.
module dummy_ip_s00_axi_slave
    import dummy_ip_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned NUM_REGS   = 4,
    parameter logic [31:0] RESET_VAL  = 32'h0
) (
    input  logic                   ACLK,
    input  logic                   ARESETN,
    dummy_ip_s00_axi_slave_if.slave s_axi,
    output logic [NUM_REGS*32-1:0] regs_o
);

    localparam int unsigned IDX_W = ADDR_WIDTH - 2;

`ifdef DUMMY_IP_SLVERR_EN
    localparam logic [1:0] OOR_RESP = RESP_SLVERR;
`else
    localparam logic [1:0] OOR_RESP = RESP_OKAY;
`endif

    function automatic logic in_range(input logic [IDX_W-1:0] idx);
        return {1'b0, idx} < (IDX_W+1)'(NUM_REGS);
    endfunction

    wr_state_t             w_state;
    logic                  aw_ready_q, w_ready_q;
    logic                  aw_held, w_held;
    logic [IDX_W-1:0]      aw_idx;
    logic [DATA_WIDTH-1:0] w_data;
    logic [3:0]            w_strb;
    logic                  bvalid_q;
    logic [1:0]            bresp_q;

    rd_state_t             r_state;
    logic                  ar_ready_q;
    logic                  rvalid_q;
    logic [1:0]            rresp_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic                  aw_hs, w_hs, ar_hs, commit, wr_en;
    logic [IDX_W-1:0]      ar_idx;
    logic [31:0]           rd_data;

    assign aw_hs  = s_axi.AWVALID && aw_ready_q;
    assign w_hs   = s_axi.WVALID && w_ready_q;
    assign ar_hs  = s_axi.ARVALID && ar_ready_q;
    assign ar_idx = s_axi.ARADDR[ADDR_WIDTH-1:2];
    // Commit only once both halves are latched; this also makes AW/W arrival order irrelevant.
    assign commit = (w_state == W_IDLE) && aw_held && w_held;
    assign wr_en  = commit && in_range(aw_idx);

    dummy_ip_regfile #(
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W),
        .RESET_VAL(RESET_VAL)
    ) u_regfile (
        .clk    (ACLK),
        .rst_n  (ARESETN),
        .wr_en  (wr_en),
        .wr_idx (aw_idx),
        .wr_data(w_data),
        .wr_strb(w_strb),
        .rd_idx (ar_idx),
        .rd_data(rd_data),
        .regs_o (regs_o)
    );

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            w_state    <= W_IDLE;
            aw_ready_q <= 1'b0;
            w_ready_q  <= 1'b0;
            aw_held    <= 1'b0;
            w_held     <= 1'b0;
            aw_idx     <= '0;
            w_data     <= '0;
            w_strb     <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (aw_hs) begin
                        aw_held <= 1'b1;
                        aw_idx  <= s_axi.AWADDR[ADDR_WIDTH-1:2];
                    end
                    if (w_hs) begin
                        w_held <= 1'b1;
                        w_data <= s_axi.WDATA;
                        w_strb <= s_axi.WSTRB;
                    end
                    if (commit) begin
                        bvalid_q   <= 1'b1;
                        bresp_q    <= in_range(aw_idx) ? RESP_OKAY : OOR_RESP;
                        aw_ready_q <= 1'b0;
                        w_ready_q  <= 1'b0;
                        w_state    <= W_RESP;
                    end else begin
                        aw_ready_q <= !(aw_held || aw_hs);
                        w_ready_q  <= !(w_held || w_hs);
                    end
                end
                W_RESP: begin
                    if (s_axi.BREADY) begin
                        bvalid_q   <= 1'b0;
                        aw_held    <= 1'b0;
                        w_held     <= 1'b0;
                        aw_ready_q <= 1'b1;
                        w_ready_q  <= 1'b1;
                        w_state    <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Read data is sampled from the pre-edge register state, so a same-edge commit is not seen.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state    <= R_IDLE;
            ar_ready_q <= 1'b0;
            rvalid_q   <= 1'b0;
            rresp_q    <= RESP_OKAY;
            rdata_q    <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (ar_hs) begin
                        rvalid_q   <= 1'b1;
                        rdata_q    <= in_range(ar_idx) ? rd_data : '0;
                        rresp_q    <= in_range(ar_idx) ? RESP_OKAY : OOR_RESP;
                        ar_ready_q <= 1'b0;
                        r_state    <= R_DATA;
                    end else begin
                        ar_ready_q <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (s_axi.RREADY) begin
                        rvalid_q   <= 1'b0;
                        ar_ready_q <= 1'b1;
                        r_state    <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    assign s_axi.AWREADY = aw_ready_q;
    assign s_axi.WREADY  = w_ready_q;
    assign s_axi.BVALID  = bvalid_q;
    assign s_axi.BRESP   = bresp_q;
    assign s_axi.ARREADY = ar_ready_q;
    assign s_axi.RVALID  = rvalid_q;
    assign s_axi.RRESP   = rresp_q;
    assign s_axi.RDATA   = rdata_q;

endmodule

// File: tb/tb_dummy_ip_s00_axi_slave.sv
// Self-checking bench for dummy_ip_s00_axi_slave: vector table, hand-written corner sequences
// and randomized traffic against a simple array model of the register bank.
module tb_dummy_ip_s00_axi_slave;

    localparam int unsigned ADDR_WIDTH = 6;
    localparam int unsigned NUM_REGS   = 4;
    localparam logic [31:0] RESET_VAL  = 32'h0;

`ifdef DUMMY_IP_SLVERR_EN
    localparam logic [1:0] ERR = 2'b10;
`else
    localparam logic [1:0] ERR = 2'b00;
`endif

    logic                  ACLK = 1'b0;
    logic                  ARESETN = 1'b0;
    logic [NUM_REGS*32-1:0] regs_o;

    dummy_ip_s00_axi_slave_if #(.ADDR_WIDTH(ADDR_WIDTH)) bus ();

    dummy_ip_s00_axi_slave #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(ADDR_WIDTH),
        .NUM_REGS  (NUM_REGS),
        .RESET_VAL (RESET_VAL)
    ) u_dut (
        .ACLK   (ACLK),
        .ARESETN(ARESETN),
        .s_axi  (bus),
        .regs_o (regs_o)
    );

    always #5 ACLK = ~ACLK;

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] model [NUM_REGS];

    typedef struct {
        logic [5:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  exp_bresp;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_rresp;
    } vec_t;
    vec_t vecs [9];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    function automatic logic [127:0] model_flat();
        logic [127:0] r;
        for (int k = 0; k < NUM_REGS; k++) r[32*k +: 32] = model[k];
        return r;
    endfunction

    function automatic logic [31:0] merge_ref(input logic [31:0] old_w, input logic [31:0] new_w,
                                              input logic [3:0] strb);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = new_w[8*b +: 8];
        return r;
    endfunction

    // Drives AW and W with independent start delays; lat = edges from later handshake to BVALID.
    task automatic do_write(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly, input bit hold,
                            output logic [1:0] resp, output int lat);
        int cyc;
        bit aw_done, w_done, aw_hs, w_hs;
        cyc = 0; aw_done = 0; w_done = 0;
        bus.AWADDR = addr; bus.WDATA = data; bus.WSTRB = strb;
        while (!(aw_done && w_done) && cyc < 50) begin
            bus.AWVALID = !aw_done && (cyc >= aw_dly);
            bus.WVALID  = !w_done && (cyc >= w_dly);
            aw_hs = bus.AWVALID && bus.AWREADY;
            w_hs  = bus.WVALID && bus.WREADY;
            tick();
            if (aw_hs) aw_done = 1;
            if (w_hs) w_done = 1;
            cyc++;
        end
        bus.AWVALID = 0; bus.WVALID = 0;
        resp = 2'bxx; lat = -1;
        if (!(aw_done && w_done)) begin
            check("wr_handshake_timeout", 0, 1);
            return;
        end
        lat = 0;
        while (!bus.BVALID && lat < 50) begin tick(); lat++; end
        if (!bus.BVALID) begin
            check("bvalid_timeout", 0, 1);
            return;
        end
        resp = bus.BRESP;
        if (!hold) begin
            bus.BREADY = 1; tick(); bus.BREADY = 0;
        end
    endtask

    task automatic do_read(input logic [5:0] addr, input bit hold,
                           output logic [31:0] data, output logic [1:0] resp, output int lat);
        int cyc;
        bit hs;
        cyc = 0; hs = 0;
        bus.ARADDR = addr;
        while (!hs && cyc < 50) begin
            bus.ARVALID = 1;
            hs = bus.ARREADY;
            tick();
            cyc++;
        end
        bus.ARVALID = 0;
        data = 'x; resp = 2'bxx; lat = -1;
        if (!hs) begin
            check("ar_handshake_timeout", 0, 1);
            return;
        end
        lat = 0;
        while (!bus.RVALID && lat < 50) begin tick(); lat++; end
        if (!bus.RVALID) begin
            check("rvalid_timeout", 0, 1);
            return;
        end
        data = bus.RDATA; resp = bus.RRESP;
        if (!hold) begin
            bus.RREADY = 1; tick(); bus.RREADY = 0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  resp;
        logic [31:0] rd;
        logic [31:0] old_v, wd;
        logic [5:0]  addr;
        logic [3:0]  strb;
        int          lat, idx, op;

        vecs[0] = '{6'h00, 32'h0000_0001, 4'hF, 2'b00, 32'h0000_0001, 2'b00};
        vecs[1] = '{6'h04, 32'h0000_0002, 4'hF, 2'b00, 32'h0000_0002, 2'b00};
        vecs[2] = '{6'h08, 32'h0000_0003, 4'hF, 2'b00, 32'h0000_0003, 2'b00};
        vecs[3] = '{6'h0C, 32'h0000_0004, 4'hF, 2'b00, 32'h0000_0004, 2'b00};
        vecs[4] = '{6'h08, 32'hAABB_CCDD, 4'hF, 2'b00, 32'hAABB_CCDD, 2'b00};
        vecs[5] = '{6'h08, 32'h1122_3344, 4'h5, 2'b00, 32'hAA22_CC44, 2'b00};
        vecs[6] = '{6'h04, 32'hFFFF_FFFF, 4'h0, 2'b00, 32'h0000_0002, 2'b00};
        vecs[7] = '{6'h10, 32'hDEAD_BEEF, 4'hF, ERR,   32'h0000_0000, ERR};
        vecs[8] = '{6'h07, 32'h0000_AB00, 4'h2, 2'b00, 32'h0000_AB02, 2'b00};

        bus.AWADDR = '0; bus.AWPROT = '0; bus.AWVALID = 0;
        bus.WDATA = '0; bus.WSTRB = '0; bus.WVALID = 0; bus.BREADY = 0;
        bus.ARADDR = '0; bus.ARPROT = '0; bus.ARVALID = 0; bus.RREADY = 0;
        for (int k = 0; k < NUM_REGS; k++) model[k] = RESET_VAL;

        repeat (3) @(posedge ACLK);
        #1;
        check("rst_awready", bus.AWREADY, 0);
        check("rst_wready", bus.WREADY, 0);
        check("rst_arready", bus.ARREADY, 0);
        check("rst_bvalid", bus.BVALID, 0);
        check("rst_rvalid", bus.RVALID, 0);
        check("rst_rdata", bus.RDATA, 0);
        check("rst_bresp", bus.BRESP, 0);
        check("rst_regs", regs_o, model_flat());
        ARESETN = 1;
        tick();
        check("post_rst_readys", {bus.AWREADY, bus.WREADY, bus.ARREADY}, 3'b111);

        for (int i = 0; i < 9; i++) begin
            do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, 0, 0, 0, resp, lat);
            check($sformatf("vec%0d_bresp", i), resp, vecs[i].exp_bresp);
            check($sformatf("vec%0d_wlat", i), lat, 1);
            idx = int'(vecs[i].addr[5:2]);
            if (idx < NUM_REGS) model[idx] = vecs[i].exp_rdata;
            check($sformatf("vec%0d_regs", i), regs_o, model_flat());
            do_read(vecs[i].addr, 0, rd, resp, lat);
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            check($sformatf("vec%0d_rresp", i), resp, vecs[i].exp_rresp);
            check($sformatf("vec%0d_rlat", i), lat, 0);
            if (i == 3) check("regs_4321", regs_o, {32'd4, 32'd3, 32'd2, 32'd1});
        end

        // AW/W ordering: W first, AW first, same cycle
        for (int i = 0; i < 3; i++) begin
            wd = 32'h1000_0000 + i;
            do_write(6'h04, wd, 4'hF, (i == 0) ? 3 : 0, (i == 1) ? 3 : 0, 0, resp, lat);
            model[1] = wd;
            check($sformatf("order%0d_lat", i), lat, 1);
            check($sformatf("order%0d_bresp", i), resp, 2'b00);
            check($sformatf("order%0d_regs", i), regs_o, model_flat());
        end

        // Same-edge write commit and read of reg 0
        bus.AWADDR = 6'h00; bus.WDATA = 32'h55; bus.WSTRB = 4'hF;
        bus.AWVALID = 1; bus.WVALID = 1;
        check("same_pre_ready", {bus.AWREADY, bus.WREADY}, 2'b11);
        tick();
        bus.AWVALID = 0; bus.WVALID = 0;
        bus.ARADDR = 6'h00; bus.ARVALID = 1;
        check("same_arready", bus.ARREADY, 1);
        tick();
        bus.ARVALID = 0;
        old_v = model[0];
        model[0] = 32'h55;
        check("same_bvalid", bus.BVALID, 1);
        check("same_rvalid", bus.RVALID, 1);
        check("same_rdata_old", bus.RDATA, old_v);
        bus.BREADY = 1; bus.RREADY = 1;
        tick();
        bus.BREADY = 0; bus.RREADY = 0;
        check("same_regs", regs_o, model_flat());
        do_read(6'h00, 0, rd, resp, lat);
        check("same_rdata_new", rd, 32'h55);

        // Backpressure on B
        do_write(6'h0C, 32'hCAFE_F00D, 4'hF, 0, 0, 1, resp, lat);
        model[3] = 32'hCAFE_F00D;
        bus.AWADDR = 6'h00; bus.AWVALID = 1;
        for (int c = 0; c < 5; c++) begin
            check("bstall_bvalid", bus.BVALID, 1);
            check("bstall_bresp", bus.BRESP, 2'b00);
            check("bstall_awready", bus.AWREADY, 0);
            tick();
        end
        bus.AWVALID = 0;
        bus.BREADY = 1; tick(); bus.BREADY = 0;
        check("bstall_done", bus.BVALID, 0);
        check("bstall_regs", regs_o, model_flat());

        // Backpressure on R
        do_read(6'h08, 1, rd, resp, lat);
        bus.ARADDR = 6'h00; bus.ARVALID = 1;
        for (int c = 0; c < 5; c++) begin
            check("rstall_rvalid", bus.RVALID, 1);
            check("rstall_rdata", bus.RDATA, model[2]);
            check("rstall_rresp", bus.RRESP, 2'b00);
            check("rstall_arready", bus.ARREADY, 0);
            tick();
        end
        bus.ARVALID = 0;
        bus.RREADY = 1; tick(); bus.RREADY = 0;
        check("rstall_done", bus.RVALID, 0);

        // Randomized traffic
        for (int n = 0; n < 60; n++) begin
            op   = $urandom_range(0, 1);
            addr = 6'($urandom_range(0, 19));
            idx  = int'(addr[5:2]);
            if (op == 0) begin
                wd   = $urandom;
                strb = 4'($urandom_range(0, 15));
                do_write(addr, wd, strb, $urandom_range(0, 3), $urandom_range(0, 3), 0, resp, lat);
                if (idx < NUM_REGS) model[idx] = merge_ref(model[idx], wd, strb);
                check("rnd_bresp", resp, (idx < NUM_REGS) ? 2'b00 : ERR);
                check("rnd_wlat", lat, 1);
                check("rnd_regs", regs_o, model_flat());
            end else begin
                do_read(addr, 0, rd, resp, lat);
                check("rnd_rdata", rd, (idx < NUM_REGS) ? model[idx] : 32'h0);
                check("rnd_rresp", resp, (idx < NUM_REGS) ? 2'b00 : ERR);
            end
        end

        // Reset with a read pending and a lone AW latched
        bus.AWADDR = 6'h00; bus.AWVALID = 1;
        tick();
        bus.AWVALID = 0;
        do_read(6'h08, 1, rd, resp, lat);
        check("mid_rvalid_before", bus.RVALID, 1);
        #2;
        ARESETN = 0;
        #1;
        for (int k = 0; k < NUM_REGS; k++) model[k] = RESET_VAL;
        check("mid_rvalid", bus.RVALID, 0);
        check("mid_bvalid", bus.BVALID, 0);
        check("mid_awready", bus.AWREADY, 0);
        check("mid_regs", regs_o, model_flat());
        repeat (2) @(posedge ACLK);
        #1;
        ARESETN = 1;
        tick();
        bus.WDATA = 32'h99; bus.WSTRB = 4'hF; bus.WVALID = 1;
        tick();
        bus.WVALID = 0;
        tick(); tick();
        check("mid_no_commit", bus.BVALID, 0);
        check("mid_regs_after", regs_o, model_flat());
        bus.AWADDR = 6'h00; bus.AWVALID = 1;
        tick();
        bus.AWVALID = 0;
        tick();
        model[0] = 32'h99;
        check("mid_commit_bvalid", bus.BVALID, 1);
        check("mid_commit_regs", regs_o, model_flat());
        bus.BREADY = 1; tick(); bus.BREADY = 0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dummy_ip_s00_axi_slave.md
Name: dummy_ip_s00_axi_slave

Overview:
- AXI4-Lite slave register bank; the block the dummy_ip master VIP drives and the design-under-test in that bench.
- Terminates AW/W/B/AR/R channels, holds NUM_REGS 32-bit read/write registers, and exports their contents to fabric logic.
- Single outstanding write and single outstanding read; write and read paths are independent.

Parameters:
- DATA_WIDTH, 32, AXI data width; only 32 is supported.
- ADDR_WIDTH, 6, AXI address width in bytes.
- NUM_REGS, 4, number of 32-bit registers at word offsets 0x0, 0x4, ...; NUM_REGS*4 <= 2**ADDR_WIDTH.
- RESET_VAL, 32'h0, reset value of every register.

Ports:
- ACLK  in  1  clock.
- ARESETN  in  1  asynchronous active-low reset.
- AWADDR  in  ADDR_WIDTH  write address.
- AWPROT  in  3  ignored.
- AWVALID  in  1 / AWREADY  out  1  write address handshake.
- WDATA  in  32  write data.
- WSTRB  in  4  byte strobes.
- WVALID  in  1 / WREADY  out  1  write data handshake.
- BRESP  out  2 / BVALID  out  1 / BREADY  in  1  write response.
- ARADDR  in  ADDR_WIDTH  read address.
- ARPROT  in  3  ignored.
- ARVALID  in  1 / ARREADY  out  1  read address handshake.
- RDATA  out  32 / RRESP  out  2 / RVALID  out  1 / RREADY  in  1  read data.
- regs_o  out  NUM_REGS*32  register contents; reg k occupies bits [32k+31:32k].

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - All registers = RESET_VAL.
  - AWREADY = WREADY = ARREADY = 0 while ARESETN = 0; 1 from the first edge after release.
  - BVALID = RVALID = 0; BRESP = RRESP = 2'b00; RDATA = 0.
- Register index = addr[ADDR_WIDTH-1:2]; addr[1:0] ignored.
- Write path (states W_IDLE, W_RESP):
  - AWREADY=1 only in W_IDLE with no AW latched; WREADY=1 only in W_IDLE with no W latched.
  - AW and W may arrive in either order or in the same cycle; each is latched on its handshake.
  - The edge on which both are held: register updates byte-wise per WSTRB (strobe 0 keeps the old byte); BVALID=1 with BRESP; state -> W_RESP.
  - W_RESP: BVALID held stable until BREADY; on B handshake, clear latches, -> W_IDLE.
  - Write latency: B visible 1 cycle after the later of the AW/W handshakes.
  - WSTRB=0 performs no update and still responds OKAY.
- Read path (states R_IDLE, R_DATA):
  - ARREADY=1 in R_IDLE. On AR handshake, RDATA is captured from register state before that edge; RVALID=1 next cycle.
  - RDATA/RRESP held stable until RREADY; -> R_IDLE. Back-to-back reads: 1 idle cycle minimum (ARREADY=0 in R_DATA).
- Simultaneous write commit and read of the same register: the read returns the old value; the new value is visible to the next read.
- regs_o reflects a write on the cycle after commit.
- Reset mid-transaction: pending AW/W latches, BVALID and RVALID clear immediately; partial writes are not committed.
- Out-of-range address (index >= NUM_REGS): see Optional Feature.

Optional Feature:
- Macro: DUMMY_IP_SLVERR_EN.
- Defined: an out-of-range write is dropped with BRESP=2'b10 (SLVERR); an out-of-range read returns RDATA=0 with RRESP=2'b10.
- Undefined: an out-of-range write is dropped with BRESP=OKAY; an out-of-range read returns RDATA=0 with RRESP=OKAY.
- In-range behaviour is identical in both builds.

Decomposition:
- Package dummy_ip_pkg holds:
  - AXI response constants RESP_OKAY=2'b00 and RESP_SLVERR=2'b10.
  - Write and read state enums.
  - Function byte_merge(old, new, strb).
- Sub-module dummy_ip_regfile: NUM_REGS x 32 storage with strobed write port, one combinational read port, and flattened regs_o. The AXI FSMs stay in the top module.

Test Plan:
- Reset, then write 0x1, 0x2, 0x3, 0x4 to 0x0/0x4/0x8/0xC with WSTRB=0xF; read back -> each RDATA matches, RRESP=OKAY, regs_o = {4,3,2,1}.
- W presented 3 cycles before AW, then AW before W, then both in the same cycle, targeting 0x4 -> each write commits once; BVALID 1 cycle after the later handshake; BRESP=OKAY.
- Write 0xAABBCCDD to 0x8, then 0x11223344 with WSTRB=4'b0101 -> read returns 0xAA22CC44.
- BREADY/RREADY held low 5 cycles -> BVALID/RVALID/BRESP/RDATA stable, no new AW/AR accepted; released -> completes.
- Write 0x55 to 0x0 and read 0x0 committing in the same cycle (prior value 0x1) -> RDATA=0x1; next read returns 0x55.
- Access 0x10 -> with DUMMY_IP_SLVERR_EN: BRESP/RRESP=2'b10, RDATA=0. Without it: OKAY, RDATA=0. regs_o is unchanged in both builds.
- ARESETN pulsed low while RVALID=1 -> RVALID=0 immediately; regs_o = RESET_VAL.
